// File: rtl/pulse_pkg.sv
// Shared types and timing constants for the pulse input path
// (pulse_conditioner and pulse_width_counter).
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } pulse_state_e;

  localparam int CLK_FREQ_HZ  = 50_000_000;
  // Also used by pulse_width_counter for its ms conversion.
  localparam int DEBOUNCE_1MS = CLK_FREQ_HZ / 1000;

endpackage

// File: rtl/pulse_conditioner_if.sv
// Pin-side and conditioned-side signals of the pulse conditioner.
// The master drives the raw pin level and enable; the slave returns the clean level.
interface pulse_conditioner_if #(
  parameter int GLITCH_W = 16
);

  logic                enable;
  logic                raw_in;
  logic                pulse_out;
  logic                rise_tick;
  logic                fall_tick;
  logic                busy;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (
    output enable,
    output raw_in,
    input  pulse_out,
    input  rise_tick,
    input  fall_tick,
    input  busy,
    input  glitch_cnt
  );

  modport slave (
    input  enable,
    input  raw_in,
    output pulse_out,
    output rise_tick,
    output fall_tick,
    output busy,
    output glitch_cnt
  );

endinterface

// File: rtl/pulse_conditioner_chk.sv
// Tick/level consistency properties of the conditioner outputs.
module pulse_conditioner_chk (
  input logic clk,
  input logic rst,
  input logic pulse_out,
  input logic rise_tick,
  input logic fall_tick,
  input logic busy
);

  a_ticks_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(rise_tick && fall_tick));

  a_rise_level: assert property (@(posedge clk) disable iff (rst)
    rise_tick |-> pulse_out);

  a_fall_level: assert property (@(posedge clk) disable iff (rst)
    fall_tick |-> !pulse_out);

  a_busy_no_tick: assert property (@(posedge clk) disable iff (rst)
    busy |-> !(rise_tick || fall_tick));

endmodule

// File: rtl/sync_ff.sv
// Multi-stage flop synchroniser for a single asynchronous bit; every stage clears to 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_r;

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_ff: STAGES must be at least 2");
  end

  // Shift the raw bit through the chain; bit 0 is the metastable first stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff_r <= {STAGES{1'b0}};
    end else begin
      ff_r <= {ff_r[STAGES-2:0], d};
    end
  end

  assign q = ff_r[STAGES-1];

endmodule

// File: rtl/pulse_conditioner.sv
// Synchronises and debounces a bouncy pin level into a clean level plus edge ticks,
// counting rejected (too short) transitions in a saturating counter.
module pulse_conditioner
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS,
  parameter int GLITCH_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  pulse_conditioner_if.slave bus
);

  localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE_LOW  = IDLE_LOW;
  localparam logic [1:0] ST_WAIT_HIGH = WAIT_HIGH;
  localparam logic [1:0] ST_IDLE_HIGH = IDLE_HIGH;
  localparam logic [1:0] ST_WAIT_LOW  = WAIT_LOW;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pulse_conditioner: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("pulse_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end
  if (GLITCH_W < 1) begin : g_bad_glitch_w
    $error("pulse_conditioner: GLITCH_W must be at least 1");
  end

  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    logic [GLITCH_W-1:0] r;
    if (v == {GLITCH_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + GLITCH_W'(1);
    end
    return r;
  endfunction

  logic                s_s;
  logic [1:0]          state_r, state_nx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nx_s;
  logic                pulse_r, pulse_nx_s;
  logic                rise_r, rise_nx_s;
  logic                fall_r, fall_nx_s;
  logic                busy_r, busy_nx_s;
  logic                glitch_inc_s;
  logic [GLITCH_W-1:0] glitch_r;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.raw_in),
    .q   (s_s)
  );

  // Debounce FSM: a transition is accepted only after s stays at the new level
  // for DEBOUNCE_CYCLES+1 consecutive edges; an early return counts as a glitch.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    pulse_nx_s   = pulse_r;
    rise_nx_s    = 1'b0;
    fall_nx_s    = 1'b0;
    glitch_inc_s = 1'b0;

    if (!bus.enable) begin
      // Aborting a pending qualification here is not a glitch.
      state_nx_s = ST_IDLE_LOW;
      cnt_nx_s   = {CNT_W{1'b0}};
      pulse_nx_s = 1'b0;
      fall_nx_s  = pulse_r;
    end else begin
      case (state_r)
        ST_IDLE_LOW: begin
          if (s_s) begin
            state_nx_s = ST_WAIT_HIGH;
            cnt_nx_s   = {CNT_W{1'b0}};
          end else begin
            state_nx_s = ST_IDLE_LOW;
          end
        end
        ST_WAIT_HIGH: begin
          if (!s_s) begin
            state_nx_s   = ST_IDLE_LOW;
            cnt_nx_s     = {CNT_W{1'b0}};
            glitch_inc_s = 1'b1;
          end else if (cnt_r == CNT_MAX) begin
            state_nx_s = ST_IDLE_HIGH;
            cnt_nx_s   = {CNT_W{1'b0}};
            pulse_nx_s = 1'b1;
            rise_nx_s  = 1'b1;
          end else begin
            cnt_nx_s = cnt_r + CNT_W'(1);
          end
        end
        ST_IDLE_HIGH: begin
          if (!s_s) begin
            state_nx_s = ST_WAIT_LOW;
            cnt_nx_s   = {CNT_W{1'b0}};
          end else begin
            state_nx_s = ST_IDLE_HIGH;
          end
        end
        ST_WAIT_LOW: begin
          if (s_s) begin
            state_nx_s   = ST_IDLE_HIGH;
            cnt_nx_s     = {CNT_W{1'b0}};
            glitch_inc_s = 1'b1;
          end else if (cnt_r == CNT_MAX) begin
            state_nx_s = ST_IDLE_LOW;
            cnt_nx_s   = {CNT_W{1'b0}};
            pulse_nx_s = 1'b0;
            fall_nx_s  = 1'b1;
          end else begin
            cnt_nx_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_nx_s = ST_IDLE_LOW;
          cnt_nx_s   = {CNT_W{1'b0}};
          pulse_nx_s = 1'b0;
        end
      endcase
    end

    busy_nx_s = (state_nx_s == ST_WAIT_HIGH) || (state_nx_s == ST_WAIT_LOW);
  end

  // State, counter and all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE_LOW;
      cnt_r    <= {CNT_W{1'b0}};
      pulse_r  <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      busy_r   <= 1'b0;
      glitch_r <= {GLITCH_W{1'b0}};
    end else begin
      state_r  <= state_nx_s;
      cnt_r    <= cnt_nx_s;
      pulse_r  <= pulse_nx_s;
      rise_r   <= rise_nx_s;
      fall_r   <= fall_nx_s;
      busy_r   <= busy_nx_s;
      glitch_r <= glitch_inc_s ? sat_inc(glitch_r) : glitch_r;
    end
  end

  assign bus.pulse_out  = pulse_r;
  assign bus.rise_tick  = rise_r;
  assign bus.fall_tick  = fall_r;
  assign bus.busy       = busy_r;
  assign bus.glitch_cnt = glitch_r;

  pulse_conditioner_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .pulse_out (pulse_r),
    .rise_tick (rise_r),
    .fall_tick (fall_r),
    .busy      (busy_r)
  );

endmodule

// File: tb/tb_pulse_conditioner.sv
// Bench for pulse_conditioner: a reset/edge vector table, hand-written corner sequences
// and randomized bouncy stimulus, all checked against a run-length reference model.
module tb_pulse_conditioner;

  localparam int SS  = 2;
  localparam int DB  = 8;
  localparam int GWA = 16;
  localparam int GWB = 2;
  localparam int GLA_MAX = (1 << GWA) - 1;
  localparam int GLB_MAX = (1 << GWB) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic raw = 1'b0;

  always #5 clk = ~clk;

  pulse_conditioner_if #(.GLITCH_W(GWA)) bus_a ();
  pulse_conditioner_if #(.GLITCH_W(GWB)) bus_b ();

  assign bus_a.enable = en;
  assign bus_a.raw_in = raw;
  assign bus_b.enable = en;
  assign bus_b.raw_in = raw;

  pulse_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .GLITCH_W(GWA)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave));

  pulse_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .GLITCH_W(GWB)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: delay line for the synchroniser, then a run-length rule.
  bit m_sync [SS];
  bit m_po, m_rise, m_fall, m_busy;
  int m_run, m_gla, m_glb;

  // Measurements of dut_a for the hand-written sequences.
  int e_idx, rise_at, fall_at, hi_len, n_rise, n_fall;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit s;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (rst) begin
      for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
      m_po = 1'b0; m_run = 0; m_gla = 0; m_glb = 0;
    end else begin
      s = m_sync[SS-1];
      for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = raw;
      if (!en) begin
        m_fall = m_po;
        m_po   = 1'b0;
        m_run  = 0;
      end else if (s != m_po) begin
        m_run++;
        if (m_run == DB + 1) begin
          m_po   = s;
          m_rise = s;
          m_fall = !s;
          m_run  = 0;
        end
      end else if (m_run > 0) begin
        if (m_gla < GLA_MAX) m_gla++;
        if (m_glb < GLB_MAX) m_glb++;
        m_run = 0;
      end
    end
    m_busy = (m_run > 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("pulse_out", int'(bus_a.pulse_out), int'(m_po));
    chk("rise_tick", int'(bus_a.rise_tick), int'(m_rise));
    chk("fall_tick", int'(bus_a.fall_tick), int'(m_fall));
    chk("busy", int'(bus_a.busy), int'(m_busy));
    chk("glitch_cnt", int'(bus_a.glitch_cnt), m_gla);
    chk("pulse_out_b", int'(bus_b.pulse_out), int'(m_po));
    chk("glitch_cnt_b", int'(bus_b.glitch_cnt), m_glb);
    e_idx++;
    if (bus_a.rise_tick) begin
      n_rise++;
      if (rise_at < 0) rise_at = e_idx;
    end
    if (bus_a.fall_tick) begin
      n_fall++;
      if (fall_at < 0) fall_at = e_idx;
    end
    if (bus_a.pulse_out) hi_len++;
  endtask

  task automatic clear_meas();
    e_idx = 0; rise_at = -1; fall_at = -1; hi_len = 0; n_rise = 0; n_fall = 0;
  endtask

  task automatic hold(input logic lvl, input int n);
    raw = lvl;
    for (int k = 0; k < n; k++) step();
  endtask

  typedef struct {
    logic rst, en, raw;
    logic po, rise, fall, busy;
    int   gl;
  } vec_t;

  vec_t tbl[$];
  int   sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    clear_meas();

    // Reset held 3 cycles with raw high, then a full rise and fall (L = 11).
    for (int k = 0; k < 3; k++) tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0});
    for (int k = 1; k <= 14; k++)
      tbl.push_back('{1'b0, 1'b1, 1'b1, (k >= 11), (k == 11), 1'b0, (k >= 3 && k <= 10), 0});
    for (int k = 1; k <= 13; k++)
      tbl.push_back('{1'b0, 1'b1, 1'b0, (k < 11), 1'b0, (k == 11), (k >= 3 && k <= 10), 0});

    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; raw = tbl[i].raw;
      step();
      chk("tbl_pulse_out", int'(bus_a.pulse_out), int'(tbl[i].po));
      chk("tbl_rise_tick", int'(bus_a.rise_tick), int'(tbl[i].rise));
      chk("tbl_fall_tick", int'(bus_a.fall_tick), int'(tbl[i].fall));
      chk("tbl_busy", int'(bus_a.busy), int'(tbl[i].busy));
      chk("tbl_glitch", int'(bus_a.glitch_cnt), tbl[i].gl);
    end

    // Clean 40-cycle pulse.
    clear_meas(); hold(1'b1, 40); hold(1'b0, 60);
    chk("clean_rise_at", rise_at, 11);
    chk("clean_fall_at", fall_at, 51);
    chk("clean_high_len", hi_len, 40);
    chk("clean_ticks", n_rise + n_fall, 2);
    chk("clean_glitch", int'(bus_a.glitch_cnt), 0);

    // Shortest accepted pulse.
    clear_meas(); hold(1'b1, 9); hold(1'b0, 30);
    chk("min9_rise_at", rise_at, 11);
    chk("min9_fall_at", fall_at, 20);
    chk("min9_high_len", hi_len, 9);
    chk("min9_glitch", int'(bus_a.glitch_cnt), 0);

    // One cycle shorter is rejected.
    clear_meas(); hold(1'b1, 8); hold(1'b0, 30);
    chk("rej8_rises", n_rise, 0);
    chk("rej8_high_len", hi_len, 0);
    chk("rej8_glitch", int'(bus_a.glitch_cnt), 1);

    // Short low dip inside a long high.
    clear_meas(); hold(1'b1, 30); hold(1'b0, 3); hold(1'b1, 30); hold(1'b0, 30);
    chk("dip_rises", n_rise, 1);
    chk("dip_falls", n_fall, 1);
    chk("dip_high_len", hi_len, 63);
    chk("dip_glitch", int'(bus_a.glitch_cnt), 2);

    // Drop enable while pulse_out is high, then re-enable with raw high.
    hold(1'b1, 20);
    chk("en_pre_level", int'(bus_a.pulse_out), 1);
    en = 1'b0; step();
    chk("en_drop_level", int'(bus_a.pulse_out), 0);
    chk("en_drop_fall", int'(bus_a.fall_tick), 1);
    hold(1'b1, 4);
    chk("en_off_busy", int'(bus_a.busy), 0);
    en = 1'b1; clear_meas(); step();
    chk("en_first_busy", int'(bus_a.busy), 1);
    hold(1'b1, 11);
    chk("en_rise_at", rise_at, 9);
    chk("en_rises", n_rise, 1);
    hold(1'b0, 30);

    // Drop enable during WAIT_HIGH: no tick, no glitch.
    clear_meas(); hold(1'b1, 5);
    chk("wait_busy", int'(bus_a.busy), 1);
    en = 1'b0; hold(1'b1, 3);
    chk("abort_busy", int'(bus_a.busy), 0);
    chk("abort_ticks", n_rise + n_fall, 0);
    chk("abort_glitch", int'(bus_a.glitch_cnt), 2);
    hold(1'b0, 3); en = 1'b1; hold(1'b0, 10);
    chk("abort_glitch_after", int'(bus_a.glitch_cnt), 2);

    // Reset mid-qualification restarts full latency.
    hold(1'b1, 6);
    rst = 1'b1; step();
    chk("rstq_busy", int'(bus_a.busy), 0);
    chk("rstq_glitch", int'(bus_a.glitch_cnt), 0);
    rst = 1'b0; clear_meas(); hold(1'b1, 14);
    chk("rstq_rise_at", rise_at, 11);
    chk("rstq_falls", n_fall, 0);
    hold(1'b0, 30);

    // Saturation of the 2-bit counter against the 16-bit one.
    for (int g = 0; g < 5; g++) begin
      hold(1'b1, 3); hold(1'b0, 20);
      chk("sat_glitch_b", int'(bus_b.glitch_cnt), sat_exp[g]);
      chk("sat_glitch_a", int'(bus_a.glitch_cnt), g + 1);
    end

    // Randomized bouncy pulses with occasional enable drops and resets.
    begin
      logic lvl;
      int nb, len;
      lvl = 1'b0;
      for (int seg = 0; seg < 250; seg++) begin
        lvl = ~lvl;
        nb  = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) begin
          hold(lvl, $urandom_range(1, 2));
          hold(~lvl, 1);
        end
        raw = lvl;
        len = $urandom_range(1, 26);
        for (int k = 0; k < len; k++) begin
          en  = ($urandom_range(0, 39) != 0);
          rst = ($urandom_range(0, 299) == 0);
          step();
        end
        rst = 1'b0;
        en  = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_conditioner.md
Name: pulse_conditioner

Overview:
Input conditioning stage that feeds pulse_width_counter. It takes an asynchronous, bouncy raw pulse from a pin and synchronises it to clk. It debounces the level with a qualification counter and drives a clean level to pulse_width_counter.pulse_in, plus one-cycle rise/fall ticks. A saturating glitch counter reports rejected transitions for board bring-up.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops (legal >= 2; elaboration error otherwise)
DEBOUNCE_CYCLES, 50_000, consecutive stable cycles needed to accept a transition (1 ms at 50 MHz; legal >= 1)
GLITCH_W, 16, width of glitch_cnt

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous, active-high reset
enable  input  1  1 = conditioning active; 0 = force output low
raw_in  input  1  asynchronous raw pulse from pin
pulse_out  output  1  debounced level, connects to pulse_width_counter.pulse_in
rise_tick  output  1  one-cycle strobe on pulse_out 0->1
fall_tick  output  1  one-cycle strobe on pulse_out 1->0
busy  output  1  high while a transition is being qualified (WAIT states)
glitch_cnt  output  GLITCH_W  count of rejected transitions, saturating

Behaviour:
- Reset (rst sampled high at a rising edge): all synchroniser flops are 0, state is IDLE_LOW, qualification counter is 0, and pulse_out, rise_tick, fall_tick, busy and glitch_cnt are all 0. Reset has priority over everything else.
- Synchroniser: an SYNC_STAGES-deep flop chain on raw_in runs regardless of enable. Its last stage is s.
- Counter width is clog2(DEBOUNCE_CYCLES) bits, minimum 1.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. All outputs are registered.
  - IDLE_LOW: if s = 1, go to WAIT_HIGH and set cnt to 0.
  - WAIT_HIGH:
    - if s = 0, go to IDLE_LOW and increment glitch_cnt;
    - else if cnt = DEBOUNCE_CYCLES-1, go to IDLE_HIGH, set pulse_out to 1, and pulse rise_tick for 1 cycle;
    - else increment cnt.
  - IDLE_HIGH and WAIT_LOW mirror the above with the polarity inverted. Completing WAIT_LOW clears pulse_out and pulses fall_tick.
- busy = 1 exactly in WAIT_HIGH and WAIT_LOW.
- Latency: take edge 1 as the first edge that samples the new raw level. pulse_out and its tick change after edge L = SYNC_STAGES + DEBOUNCE_CYCLES + 1.
- Minimum accepted pulse: raw level held for DEBOUNCE_CYCLES+1 sampling edges. A level held for DEBOUNCE_CYCLES edges is rejected and counted as a glitch.
- glitch_cnt saturates at all-ones and never wraps.
- enable = 0:
  - On the next edge the FSM goes to IDLE_LOW, cnt is cleared, and pulse_out goes to 0.
  - If pulse_out was 1, fall_tick pulses once.
  - A pending WAIT is aborted without incrementing glitch_cnt.
- Invariant: rise_tick and fall_tick coincide exactly with pulse_out edges, and are never high together.
- On re-enable with s = 1, the FSM enters WAIT_HIGH on the first edge with enable = 1. rise_tick follows DEBOUNCE_CYCLES edges later.
- Reset mid-qualification: the pending transition is discarded and no tick is produced. Because the synchroniser is also cleared, full latency L applies again afterwards.
- Downstream compatibility: a pulse_out high run equals the raw high run length. Edge jitter is bounded only by synchroniser sampling, and both edges are delayed by the same L.

Decomposition:
- Package pulse_pkg holds:
  - the state enum (IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW);
  - CLK_FREQ_HZ = 50_000_000;
  - DEBOUNCE_1MS = CLK_FREQ_HZ/1000, shared with pulse_width_counter's ms conversion.
- One sub-module, sync_ff, parameterised by stage count and reset to 0, instantiated once for raw_in.

Test Plan:
All scenarios use SYNC_STAGES = 2 and DEBOUNCE_CYCLES = 8, giving L = 11.
- Reset: hold rst for 3 cycles with raw_in = 1. Every output reads 0 during reset. After release, rise_tick fires exactly 11 edges later.
- Clean pulse: raw_in high for 40 cycles, then low.
  - rise_tick is high for 1 cycle at edge 11.
  - pulse_out is high for exactly 40 cycles.
  - fall_tick fires 11 edges after the first low sample.
  - glitch_cnt stays 0.
- Boundary:
  - A raw high of 9 cycles yields a 9-cycle pulse_out with both ticks.
  - A raw high of 8 cycles leaves pulse_out at 0 and sets glitch_cnt to 1.
  - A raw low dip of 3 cycles inside a long high leaves pulse_out at 1 and increments glitch_cnt.
- Saturation: with GLITCH_W = 2, apply 5 separate 3-cycle raw glitches. glitch_cnt reads 1, 2, 3, 3, 3.
- Enable:
  - Drop enable while pulse_out = 1: pulse_out goes to 0 on the next edge with one fall_tick.
  - Re-assert enable with raw_in = 1: rise_tick fires 8 edges after the first enabled edge.
  - Drop enable during WAIT_HIGH: no tick, and glitch_cnt is unchanged.
- Downstream loopback: connect pulse_out to pulse_width_counter and drive bouncy raw pulses of 100/200/50 us. count equals the raw width in cycles, ±1.
